width_downsizer: RTL and testbench
==================================

WIDTH_DOWNSIZER -- requirements
Module: width_downsizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, input word width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, output beat width in bits.
REQ-003 SHALL have parameter LSB_FIRST, default 1; 1 = least-significant slice emitted first, 0 = most-significant first.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port s_valid_i, input, 1, upstream word valid; driven by the FIFO read side.
REQ-007 SHALL have port s_data_i, input, IN_WIDTH, upstream word.
REQ-008 SHALL have port s_ready_o, output, 1, block accepts a word this cycle.
REQ-009 SHALL have port m_valid_o, output, 1, output beat valid.
REQ-010 SHALL have port m_data_o, output, OUT_WIDTH, output beat.
REQ-011 SHALL have port m_last_o, output, 1, current beat is final slice of its word.
REQ-012 SHALL have port m_ready_i, input, 1, downstream accepts beat.
REQ-013 SHALL have port busy_o, output, 1, high while a word is held.

Function
REQ-014 SHALL require IN_WIDTH to be an integer multiple of OUT_WIDTH; RATIO = IN_WIDTH/OUT_WIDTH.
REQ-015 SHALL require RATIO >= 2; elaboration fails otherwise.
REQ-016 SHALL use a beat counter of width log2ceil(RATIO), range 0..RATIO-1.
REQ-017 SHALL implement two states: IDLE (no word held) and BUSY (word held in internal register).
REQ-018 SHALL complete an input handshake when s_valid_i && s_ready_o; an output handshake when m_valid_o && m_ready_i.
REQ-019 SHALL drive s_ready_o = IDLE, or BUSY with beat counter = RATIO-1 and m_ready_i high.
REQ-020 SHALL drive m_valid_o = BUSY, registered; m_valid_o SHALL NOT depend combinationally on s_valid_i.
REQ-021 SHALL, on input handshake, load s_data_i into the word register, clear the counter, and enter or stay in BUSY.
REQ-022 SHALL present the first beat of an accepted word in the cycle after acceptance (latency 1).
REQ-023 SHALL, with LSB_FIRST=1, drive m_data_o = word[k*OUT_WIDTH +: OUT_WIDTH] for counter value k; with LSB_FIRST=0, slice RATIO-1-k.
REQ-024 SHALL drive m_last_o high exactly when m_valid_o is high and the counter = RATIO-1.
REQ-025 SHALL increment the counter on each non-final output handshake.
REQ-026 SHALL, on final-beat handshake without input handshake, return to IDLE with counter 0.
REQ-027 SHALL, on simultaneous final-beat and input handshake, load the new word and stay BUSY with counter 0; sustained throughput is one beat per cycle with no bubble.
REQ-028 SHALL hold m_data_o, m_last_o and the counter stable while m_valid_o && !m_ready_i.
REQ-029 SHALL leave the word register unchanged when s_valid_i is high and s_ready_o is low; no word is dropped or duplicated.
REQ-030 SHALL drive busy_o equal to m_valid_o.

Reset
REQ-031 SHALL, when rst_i is high at a rising edge, enter IDLE, clear the counter and clear the word register to 0.
REQ-032 SHALL drive m_valid_o=0, m_last_o=0, m_data_o=0, busy_o=0 and s_ready_o=1 in the cycle following reset.
REQ-033 SHALL, on reset asserted mid-word, discard the remaining beats; no beat of that word appears after reset.
REQ-034 SHALL ignore s_valid_i in any cycle where rst_i is high.

Verification
REQ-035 SHALL cover single word, defaults: accept 0xA1B2C3D4, m_ready_i=1 -> beats D4,C3,B2,A1 on 4 consecutive cycles starting 1 cycle after acceptance, m_last_o only on A1.
REQ-036 SHALL cover back-to-back: words 0x03020100 then 0x07060504 offered continuously, m_ready_i=1 -> beats 00..07 on 8 consecutive cycles, s_ready_o high on beat 03 cycle, m_last_o on 03 and 07.
REQ-037 SHALL cover backpressure: m_ready_i low 3 cycles during beat B2 of 0xA1B2C3D4 -> m_data_o holds B2 for those cycles, s_ready_o stays 0, sequence resumes B2,A1.
REQ-038 SHALL cover reset mid-word: rst_i high 1 cycle after beat C3 of 0xA1B2C3D4 -> next cycle m_valid_o=0, s_ready_o=1; B2 and A1 never emitted.
REQ-039 SHALL cover LSB_FIRST=0: accept 0xA1B2C3D4 -> beats A1,B2,C3,D4, m_last_o on D4.
REQ-040 SHALL cover random stimulus: random s_valid_i/m_ready_i over 1000 words -> scoreboard reassembly matches input order exactly, no protocol violations.

Source files
------------

// File: rtl/width_downsizer.sv
// Width downsizer: takes one IN_WIDTH word per input handshake and replays it
// as RATIO = IN_WIDTH/OUT_WIDTH narrower beats on a valid/ready output port.
// The next word can be accepted during the final beat, so back-to-back words
// stream out at one beat per clock with no bubble.
module width_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_valid_i,
    input  logic [IN_WIDTH-1:0]  s_data_i,
    output logic                 s_ready_o,
    output logic                 m_valid_o,
    output logic [OUT_WIDTH-1:0] m_data_o,
    output logic                 m_last_o,
    input  logic                 m_ready_i,
    output logic                 busy_o
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    // Refuse to elaborate a configuration that cannot be sliced evenly or
    // that would not actually narrow the data path.
    if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_multiple
        $error("width_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (RATIO < 2) begin : g_bad_ratio
        $error("width_downsizer: IN_WIDTH/OUT_WIDTH must be at least 2");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                 state_q;
    logic [IN_WIDTH-1:0]    word_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   m_valid_q;
    logic                   m_last_q;
    logic [OUT_WIDTH-1:0]   m_data_q;

    logic                   in_fire;
    logic                   out_fire;
    logic                   at_last;
    logic [CNT_W-1:0]       cnt_next;

    // Select the slice of a word that belongs to a given beat number; the
    // emission order is fixed by LSB_FIRST.
    function automatic logic [OUT_WIDTH-1:0] pick_slice(
        input logic [IN_WIDTH-1:0] word,
        input logic [CNT_W-1:0]    beat
    );
        int idx;
        if (LSB_FIRST != 0) begin
            idx = int'(beat);
        end else begin
            idx = RATIO - 1 - int'(beat);
        end
        return OUT_WIDTH'(word >> (idx * OUT_WIDTH));
    endfunction

    assign at_last   = (cnt_q == LAST_CNT);
    assign cnt_next  = cnt_q + CNT_W'(1);
    assign out_fire  = m_valid_q && m_ready_i;
    // A new word fits when nothing is held, or when the held word's final
    // beat leaves this very cycle.
    assign s_ready_o = (state_q == IDLE) || (at_last && m_ready_i);
    assign in_fire   = s_valid_i && s_ready_o;

    // Beat sequencer: loads words, steps through slices and registers every
    // output so that m_valid_o never sees s_valid_i combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            word_q    <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (in_fire) begin
            state_q   <= BUSY;
            word_q    <= s_data_i;
            cnt_q     <= '0;
            m_valid_q <= 1'b1;
            m_last_q  <= (LAST_CNT == '0);
            m_data_q  <= pick_slice(s_data_i, '0);
        end else if (out_fire) begin
            if (at_last) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                m_data_q  <= '0;
            end else begin
                cnt_q     <= cnt_next;
                m_last_q  <= (cnt_next == LAST_CNT);
                m_data_q  <= pick_slice(word_q, cnt_next);
            end
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_last_o  = m_last_q;
    assign busy_o    = m_valid_q;

endmodule

// File: tb/tb_width_downsizer.sv
// Bench for width_downsizer: directed scenarios plus a long random run, with
// a scoreboard of expected beats filled at every input handshake and drained
// at every output handshake.
module tb_width_downsizer;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy;

    logic        s_valid_msb;
    logic [31:0] s_data_msb;
    logic        s_ready_msb;
    logic        m_valid_msb;
    logic [7:0]  m_data_msb;
    logic        m_last_msb;
    logic        m_ready_msb;
    logic        busy_msb;

    int          check_count = 0;
    int          pass_count  = 0;
    logic        mon_en      = 1'b0;

    logic [8:0]  sb_q[$];
    logic        stall_q     = 1'b0;
    logic [7:0]  held_data   = '0;
    logic        held_last   = 1'b0;

    width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid),
        .s_data_i  (s_data),
        .s_ready_o (s_ready),
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_ready_i (m_ready),
        .busy_o    (busy)
    );

    width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(0)) dut_msb (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid_msb),
        .s_data_i  (s_data_msb),
        .s_ready_o (s_ready_msb),
        .m_valid_o (m_valid_msb),
        .m_data_o  (m_data_msb),
        .m_last_o  (m_last_msb),
        .m_ready_i (m_ready_msb),
        .busy_o    (busy_msb)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls forever.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data,
                                 input logic ready);
        s_valid = valid;
        s_data  = data;
        m_ready = ready;
    endtask

    task automatic checkDrained(input string tag);
        #1;
        checkOutput(tag, 64'(sb_q.size()), 64'(0));
    endtask

    // Scoreboard monitor: samples mid-cycle, pops one expected beat per
    // output handshake, pushes RATIO beats per input handshake and checks
    // that a stalled beat is held unchanged.
    always @(negedge clk) begin
        logic [8:0]  exp_beat;
        logic [31:0] w;
        if (mon_en) begin
            if (rst) begin
                sb_q.delete();
                stall_q = 1'b0;
            end else begin
                checkOutput("busy_eq_valid", 64'(busy), 64'(m_valid));
                if (stall_q) begin
                    checkOutput("stall_valid_held", 64'(m_valid), 64'(1));
                    checkOutput("stall_data_held", 64'(m_data), 64'(held_data));
                    checkOutput("stall_last_held", 64'(m_last), 64'(held_last));
                end
                if (m_valid && m_ready) begin
                    checkOutput("sb_beat_expected", 64'(sb_q.size() > 0), 64'(1));
                    if (sb_q.size() > 0) begin
                        exp_beat = sb_q.pop_front();
                        checkOutput("sb_data", 64'(m_data), 64'(exp_beat[7:0]));
                        checkOutput("sb_last", 64'(m_last), 64'(exp_beat[8]));
                    end
                end
                if (s_valid && s_ready) begin
                    w = s_data;
                    for (int k = 0; k < 4; k++) begin
                        sb_q.push_back({k == 3, w[8*k +: 8]});
                    end
                end
                stall_q   = m_valid && !m_ready;
                held_data = m_data;
                held_last = m_last;
            end
        end
    end

    // Directed scenarios followed by the random run, all in sequence.
    initial begin
        logic [31:0] w;
        logic        acc;
        logic        offering;
        logic [31:0] rand_word;
        int          sent;
        int          cyc;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        s_valid_msb = 1'b0;
        s_data_msb  = 32'h0;
        m_ready_msb = 1'b0;

        // Reset and the state right after it
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
        checkOutput("rst_m_last", 64'(m_last), 64'(0));
        checkOutput("rst_m_data", 64'(m_data), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_s_ready", 64'(s_ready), 64'(1));
        checkOutput("rst_msb_s_ready", 64'(s_ready_msb), 64'(1));
        checkOutput("rst_msb_m_valid", 64'(m_valid_msb), 64'(0));
        mon_en = 1'b1;

        // Single word, LSB first, no backpressure
        $display("[TB] single word");
        w = 32'hA1B2C3D4;
        @(posedge clk); #1;
        applyStimulus(1'b1, w, 1'b1);
        @(negedge clk);
        checkOutput("t1_s_ready_idle", 64'(s_ready), 64'(1));
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t1_valid", 64'(m_valid), 64'(1));
            checkOutput("t1_data", 64'(m_data), 64'(w[8*k +: 8]));
            checkOutput("t1_last", 64'(m_last), 64'(k == 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("t1_idle_after", 64'(m_valid), 64'(0));
        checkDrained("t1_drained");

        // Back-to-back words with no bubble
        $display("[TB] back-to-back");
        @(posedge clk); #1;
        applyStimulus(1'b1, 32'h03020100, 1'b1);
        @(negedge clk);
        checkOutput("t2_s_ready_idle", 64'(s_ready), 64'(1));
        @(posedge clk); #1;
        applyStimulus(1'b1, 32'h07060504, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("t2_valid", 64'(m_valid), 64'(1));
            checkOutput("t2_data", 64'(m_data), 64'(k));
            checkOutput("t2_last", 64'(m_last), 64'(k == 3 || k == 7));
            checkOutput("t2_s_ready", 64'(s_ready), 64'(k == 3 || k == 7));
            @(posedge clk); #1;
            if (k == 3) applyStimulus(1'b0, 32'h0, 1'b1);
        end
        @(negedge clk);
        checkOutput("t2_idle_after", 64'(m_valid), 64'(0));
        checkDrained("t2_drained");

        // Backpressure on the B2 beat while another word is offered
        $display("[TB] backpressure");
        @(posedge clk); #1;
        applyStimulus(1'b1, w, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("t3_d4", 64'(m_data), 64'(8'hD4));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t3_c3", 64'(m_data), 64'(8'hC3));
        @(posedge clk); #1;
        applyStimulus(1'b1, 32'h11223344, 1'b0);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            checkOutput("t3_stall_valid", 64'(m_valid), 64'(1));
            checkOutput("t3_stall_data", 64'(m_data), 64'(8'hB2));
            checkOutput("t3_stall_last", 64'(m_last), 64'(0));
            checkOutput("t3_stall_s_ready", 64'(s_ready), 64'(0));
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("t3_b2", 64'(m_data), 64'(8'hB2));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t3_a1", 64'(m_data), 64'(8'hA1));
        checkOutput("t3_a1_last", 64'(m_last), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t3_idle_after", 64'(m_valid), 64'(0));
        checkDrained("t3_drained");

        // Reset in the middle of a word, with a word offered during reset
        $display("[TB] reset mid-word");
        @(posedge clk); #1;
        applyStimulus(1'b1, w, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("t4_d4", 64'(m_data), 64'(8'hD4));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t4_c3", 64'(m_data), 64'(8'hC3));
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("t4_m_valid", 64'(m_valid), 64'(0));
        checkOutput("t4_s_ready", 64'(s_ready), 64'(1));
        checkOutput("t4_m_data", 64'(m_data), 64'(0));
        checkOutput("t4_m_last", 64'(m_last), 64'(0));
        checkOutput("t4_busy", 64'(busy), 64'(0));
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("t4_no_stale_beat", 64'(m_valid), 64'(0));
        end
        checkDrained("t4_drained");

        // MSB-first instance
        $display("[TB] msb first");
        @(posedge clk); #1;
        s_valid_msb = 1'b1;
        s_data_msb  = w;
        m_ready_msb = 1'b1;
        @(negedge clk);
        checkOutput("t5_s_ready_idle", 64'(s_ready_msb), 64'(1));
        @(posedge clk); #1;
        s_valid_msb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t5_valid", 64'(m_valid_msb), 64'(1));
            checkOutput("t5_data", 64'(m_data_msb), 64'(w[8*(3-k) +: 8]));
            checkOutput("t5_last", 64'(m_last_msb), 64'(k == 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("t5_idle_after", 64'(m_valid_msb), 64'(0));

        // Random valid/ready over many words; scoreboard does the checking
        $display("[TB] random run");
        acc       = 1'b0;
        offering  = 1'b0;
        rand_word = 32'h0;
        sent      = 0;
        cyc       = 0;
        while (sent < 1000 && cyc < 30000) begin
            @(posedge clk); #1;
            if (acc) begin
                offering = 1'b0;
                sent++;
            end
            if (!offering && sent < 1000 && ($urandom_range(0, 1) == 1)) begin
                offering  = 1'b1;
                rand_word = $urandom;
            end
            applyStimulus(offering, offering ? rand_word : $urandom,
                          $urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = s_valid && s_ready;
            cyc++;
        end
        checkOutput("rand_words_sent", 64'(sent), 64'(1000));
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        cyc = 0;
        while ((sb_q.size() != 0 || m_valid) && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        checkOutput("rand_idle_after", 64'(m_valid), 64'(0));
        checkDrained("rand_drained");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
